// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronizes the board reset, stretches it, then releases N_OUT domains in order.
// Optional SW_RST_EN enables the software-requested replay of the stretch/release sequence.
module reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int N_OUT          = 3,
    parameter int STEP_CYCLES    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sw_rst_req,
    output logic [N_OUT-1:0] rst_n_out,
    output logic             rst_done,
    output logic             sw_rst_ack
);
    localparam int CW = $clog2(STRETCH_CYCLES > STEP_CYCLES ? STRETCH_CYCLES : STEP_CYCLES) + 1;
    localparam int IW = N_OUT > 1 ? $clog2(N_OUT) : 1;
    typedef enum logic [2:0] {HOLD, STRETCH, RELEASE, RUN, SOFT} state_t;
    state_t           state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [N_OUT-1:0] rst_n_out_q, rst_n_out_d;
    logic             rst_done_q, rst_done_d;
    logic             sw_rst_ack_q, sw_rst_ack_d;
    logic             sync_ok;
`ifndef SW_RST_EN
    logic             unused_sw_rst_req;
    assign unused_sw_rst_req = sw_rst_req;
`endif
    assign sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
    assign sync_ok = sync_q[SYNC_STAGES-1];
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        rst_n_out_d  = rst_n_out_q;
        rst_done_d   = rst_done_q;
        sw_rst_ack_d = 1'b0;
        case (state_q)
            HOLD: if (sync_ok) begin
                state_d = STRETCH;
                cnt_d   = '0;
            end
            STRETCH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(STRETCH_CYCLES - 1)) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            RELEASE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(STEP_CYCLES - 1)) begin
                    cnt_d       = '0;
                    idx_d       = idx_q + 1'b1;
                    rst_n_out_d = rst_n_out_q | (N_OUT'(1) << idx_q);
                    if (idx_q == IW'(N_OUT - 1)) begin
                        state_d    = RUN;
                        rst_done_d = 1'b1;
                    end
                end
            end
`ifdef SW_RST_EN
            RUN: if (sw_rst_req) begin
                state_d      = SOFT;
                rst_n_out_d  = '0;
                rst_done_d   = 1'b0;
                sw_rst_ack_d = 1'b1;
            end
            SOFT: begin
                state_d = STRETCH;
                cnt_d   = '0;
            end
`endif
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HOLD;
            sync_q       <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            rst_n_out_q  <= '0;
            rst_done_q   <= 1'b0;
            sw_rst_ack_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            rst_n_out_q  <= rst_n_out_d;
            rst_done_q   <= rst_done_d;
            sw_rst_ack_q <= sw_rst_ack_d;
        end
    end
    assign rst_n_out  = rst_n_out_q;
    assign rst_done   = rst_done_q;
    assign sw_rst_ack = sw_rst_ack_q;
endmodule
